// File: rtl/fracnet_div_pkg.sv
// Shared constants and types for the fracnet sequential divider (25s / 8ns -> 16s).
// Widths, saturation limits, FSM encoding, iteration counter width.
package fracnet_div_pkg;

  localparam int A_WIDTH_DEF = 25;
  localparam int B_WIDTH_DEF = 8;
  localparam int Q_WIDTH_DEF = 16;

  localparam int Q_MAX = 32767;
  localparam int Q_MIN = -32768;

  localparam int CNT_WIDTH = $clog2(A_WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/fracnet_div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, subtract divisor if it fits.
// Combinational, zero latency, no flow control.
module fracnet_div_step #(
  parameter int B_WIDTH = 8
) (
  input  logic [B_WIDTH-1:0] rem_in,
  input  logic               bit_in,
  input  logic [B_WIDTH-1:0] b,
  output logic [B_WIDTH-1:0] rem_out,
  output logic               q_bit
);

  logic [B_WIDTH:0]   trial;
  logic [B_WIDTH-1:0] diff;

  assign trial = {rem_in, bit_in};
  // When the subtraction succeeds the true difference is below b, so the low bits are exact.
  assign diff  = trial[B_WIDTH-1:0] - b;
  assign q_bit = (trial >= {1'b0, b});
  assign rem_out = q_bit ? diff : trial[B_WIDTH-1:0];

endmodule

// File: rtl/fracnet_div_25s_8ns_16s_seq.sv
// Saturating signed/unsigned sequential divider; FRACNET_DIV_ROUND_EN adds round-half-away-from-zero.
// Latency: out_valid rises A_WIDTH+2 ce-enabled edges after the accept edge; one op in flight.
// Backpressure: result held until out_ready; in_ready only in IDLE, in_valid while busy is dropped.
module fracnet_div_25s_8ns_16s_seq
  import fracnet_div_pkg::*;
#(
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int B_WIDTH = B_WIDTH_DEF,
  parameter int Q_WIDTH = Q_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [A_WIDTH-1:0] din0,
  input  logic        [B_WIDTH-1:0] din1,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [Q_WIDTH-1:0] dout,
  output logic                      sat,
  output logic                      dbz
);

  localparam int CNT_W = $clog2(A_WIDTH);
  localparam logic [A_WIDTH:0] POS_LIM = (A_WIDTH+1)'((64'd1 << (Q_WIDTH-1)) - 64'd1);
  localparam logic [A_WIDTH:0] NEG_LIM = POS_LIM + 1'b1;
  localparam logic [Q_WIDTH-1:0] DOUT_MAX = {1'b0, {(Q_WIDTH-1){1'b1}}};
  localparam logic [Q_WIDTH-1:0] DOUT_MIN = {1'b1, {(Q_WIDTH-1){1'b0}}};

  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic               neg;
  logic [A_WIDTH-1:0] mag;
  logic [A_WIDTH-1:0] quo;
  logic [B_WIDTH-1:0] rem;
  logic [B_WIDTH-1:0] divisor;

  logic [A_WIDTH-1:0] din0_abs;
  logic [B_WIDTH-1:0] rem_nxt;
  logic               q_bit;

  logic [A_WIDTH:0]   mag_r;
  logic [A_WIDTH:0]   mag_neg;
  logic [Q_WIDTH-1:0] fix_dout;
  logic               fix_sat;
  logic               fix_dbz;

  assign in_ready = (state == IDLE);
  // Two's-complement magnitude; -2^(A_WIDTH-1) maps to 2^(A_WIDTH-1) as an unsigned value.
  assign din0_abs = din0[A_WIDTH-1] ? (~din0 + 1'b1) : din0;

  fracnet_div_step #(.B_WIDTH(B_WIDTH)) u_step (
    .rem_in  (rem),
    .bit_in  (mag[A_WIDTH-1]),
    .b       (divisor),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else if (ce) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid)              state_nxt = CALC;
      CALC: if (cnt == '0)             state_nxt = FIX;
      FIX:                             state_nxt = DONE;
      DONE: if (out_valid && out_ready) state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  always_comb begin
`ifdef FRACNET_DIV_ROUND_EN
    mag_r = {1'b0, quo} + (A_WIDTH+1)'({rem, 1'b0} >= {1'b0, divisor});
`else
    mag_r = {1'b0, quo};
`endif
    mag_neg  = ~mag_r + 1'b1;
    fix_dout = mag_r[Q_WIDTH-1:0];
    fix_sat  = 1'b0;
    fix_dbz  = 1'b0;
    if (divisor == '0) begin
      fix_dbz  = 1'b1;
      fix_sat  = 1'b1;
      fix_dout = neg ? DOUT_MIN : DOUT_MAX;
    end else if (neg) begin
      if (mag_r > NEG_LIM) begin
        fix_sat  = 1'b1;
        fix_dout = DOUT_MIN;
      end else begin
        fix_dout = mag_neg[Q_WIDTH-1:0];
      end
    end else if (mag_r > POS_LIM) begin
      fix_sat  = 1'b1;
      fix_dout = DOUT_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      neg       <= 1'b0;
      mag       <= '0;
      quo       <= '0;
      rem       <= '0;
      divisor   <= '0;
      dout      <= '0;
      sat       <= 1'b0;
      dbz       <= 1'b0;
      out_valid <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            neg     <= din0[A_WIDTH-1];
            mag     <= din0_abs;
            divisor <= din1;
            quo     <= '0;
            rem     <= '0;
            cnt     <= CNT_W'(A_WIDTH-1);
          end
        end
        CALC: begin
          mag <= {mag[A_WIDTH-2:0], 1'b0};
          quo <= {quo[A_WIDTH-2:0], q_bit};
          rem <= rem_nxt;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX: begin
          dout <= fix_dout;
          sat  <= fix_sat;
          dbz  <= fix_dbz;
        end
        DONE: begin
          // Result registers settle on DONE entry; valid is raised the following edge.
          if (!out_valid)     out_valid <= 1'b1;
          else if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fracnet_div_25s_8ns_16s_seq.sv
// Scoreboarded bench for the sequential divider: latency, rounding/saturation, dbz, ce stall, backpressure, reset.
module tb_fracnet_div_25s_8ns_16s_seq;
  import fracnet_div_pkg::*;

  typedef struct packed {
    logic signed [15:0] dout;
    logic               sat;
    logic               dbz;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               ce;
  logic               in_valid;
  logic               in_ready;
  logic signed [24:0] din0;
  logic        [7:0]  din1;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] dout;
  logic               sat;
  logic               dbz;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  fracnet_div_25s_8ns_16s_seq dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din0      (din0),
    .din1      (din1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .sat       (sat),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  function automatic exp_t model(input int a, input int b);
    exp_t   e;
    longint m, q, r;
    bit     n;
    e.sat = 1'b0;
    e.dbz = 1'b0;
    if (b == 0) begin
      e.dbz  = 1'b1;
      e.sat  = 1'b1;
      e.dout = (a < 0) ? 16'sh8000 : 16'sh7fff;
      return e;
    end
    n = (a < 0);
    m = n ? -longint'(a) : longint'(a);
    q = m / b;
    r = m % b;
`ifdef FRACNET_DIV_ROUND_EN
    if (2 * r >= b) q = q + 1;
`else
    if (r < 0) q = q + 1;
`endif
    if (n) q = -q;
    if (q > Q_MAX) begin
      q = Q_MAX;
      e.sat = 1'b1;
    end else if (q < Q_MIN) begin
      q = Q_MIN;
      e.sat = 1'b1;
    end
    e.dout = q[15:0];
    return e;
  endfunction

  task automatic issue(input int a, input int b);
    int av;
    for (int n = 0; n < 100 && !in_ready; n++) begin
      @(posedge clk); #1;
    end
    av       = a;
    in_valid = 1'b1;
    din0     = av[24:0];
    din1     = b[7:0];
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(model(a, b));
  endtask

  task automatic wait_out(input int limit, output int edges, output bit timed_out);
    edges     = 0;
    timed_out = 1'b1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      edges++;
      if (out_valid) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ce    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || dout !== 16'sd0 || sat !== 1'b0 || dbz !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b dout=%0d sat=%b dbz=%b required 1 0 0 0 0",
               in_ready, out_valid, dout, sat, dbz);
    end
    reset = 1'b0;
    ce    = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    int   edges;
    bit   to;
    exp_t e;
    issue(1000, 10);
    wait_out(100, edges, to);
    checks++;
    if (to || edges != 27) begin
      errors++;
      $display("FAIL latency: out_valid after %0d edges (timeout=%0b) required 27", edges, to);
    end
    e = exp_q.pop_front();
    checks++;
    if (dout !== 16'sd100 || sat !== 1'b0 || dbz !== 1'b0 || dout !== e.dout) begin
      errors++;
      $display("FAIL basic_1000_10: dout=%0d sat=%b dbz=%b required %0d 0 0", dout, sat, dbz, $signed(e.dout));
    end
    consume();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_patterns();
    int   pa[13] = '{-1000, 16777215, -16777216, 5, -5, 327670, 327680, -327680, -327690,
                     0, -7, -327675, 12345678};
    int   pb[13] = '{7, 1, 1, 0, 0, 10, 10, 10, 10, 3, 2, 10, 255};
    int   edges;
    bit   to;
    exp_t e;
    for (int i = 0; i < 13; i++) begin
      issue(pa[i], pb[i]);
      wait_out(100, edges, to);
      checks++;
      if (to) begin
        errors++;
        $display("FAIL pat%0d_valid: out_valid never rose within 100 edges, required rise at 27", i);
      end
      e = exp_q.pop_front();
      checks++;
      if (dout !== e.dout || sat !== e.sat || dbz !== e.dbz) begin
        errors++;
        $display("FAIL pat%0d %0d/%0d: dout=%0d sat=%b dbz=%b required %0d %b %b",
                 i, pa[i], pb[i], dout, sat, dbz, $signed(e.dout), e.sat, e.dbz);
      end
      consume();
    end
  endtask

  task automatic test_ce_stall();
    int   edges;
    bit   to;
    exp_t e;
    bit   early;
    issue(-1000, 7);
    early = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      early |= out_valid;
    end
    ce = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      early |= out_valid;
    end
    ce = 1'b1;
    wait_out(100, edges, to);
    checks++;
    if (early || to || (edges + 8) != 30) begin
      errors++;
      $display("FAIL ce_stall_latency: out_valid after %0d edges (early=%0b timeout=%0b) required 30",
               edges + 8, early, to);
    end
    e = exp_q.pop_front();
    checks++;
    if (dout !== e.dout || sat !== 1'b0) begin
      errors++;
      $display("FAIL ce_stall_result: dout=%0d sat=%b required %0d 0", dout, sat, $signed(e.dout));
    end
    consume();
  endtask

  task automatic test_backpressure();
    int   edges;
    bit   to;
    bit   bad;
    exp_t e;
    issue(1000, 10);
    wait_out(100, edges, to);
    e = exp_q.pop_front();
    in_valid = 1'b1;
    din0     = 25'sd50;
    din1     = 8'd5;
    bad      = to;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || dout !== e.dout) bad = 1'b1;
    end
    in_valid = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL backpressure_hold: out_valid=%b in_ready=%b dout=%0d required 1 0 %0d",
               out_valid, in_ready, dout, $signed(e.dout));
    end
    consume();
    checks++;
    if (out_valid !== 1'b0 || dout !== e.dout) begin
      errors++;
      $display("FAIL post_handshake_hold: out_valid=%b dout=%0d required 0 %0d", out_valid, dout, $signed(e.dout));
    end
  endtask

  task automatic test_reset_mid_calc();
    int   edges;
    bit   to;
    exp_t e;
    issue(1000, 10);
    void'(exp_q.pop_back());
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_calc: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    issue(300, 3);
    wait_out(100, edges, to);
    checks++;
    if (to || edges != 27) begin
      errors++;
      $display("FAIL after_reset_latency: %0d edges (timeout=%0b) required 27", edges, to);
    end
    e = exp_q.pop_front();
    checks++;
    if (dout !== e.dout || dout !== 16'sd100 || sat !== 1'b0 || dbz !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_result: dout=%0d sat=%b dbz=%b required 100 0 0", dout, sat, dbz);
    end
    consume();
  endtask

  initial begin
    reset     = 1'b1;
    ce        = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din0      = '0;
    din1      = '0;
    test_reset();
    test_latency();
    test_patterns();
    test_ce_stall();
    test_backpressure();
    test_reset_mid_calc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
